noc_perf_monitor: RTL and testbench
===================================

// Module: noc_perf_monitor
// PURPOSE
// - Synthesizable, parametrised successor to the bench-only throughput check: sits beside openNocTop and taps the PE-side buses.
// - Counts injections and ejections on every lane, times the run, and accumulates per-packet latency from a timestamp carried in the flit.
// - Raises sticky done / timeout flags.
// - Counters are readable on-chip, so throughput and efficiency are derived without $time.
// PARAMETERS
// - X            1    mesh columns
// - Y            2    mesh rows; N = X*Y lanes
// - x_size       1    x-address bits in the flit header
// - y_size       1    y-address bits in the flit header
// - data_width   256  payload bits; total_width = x_size+y_size+data_width
// - NUM_PACKETS  10   packets each PE injects; EXPECTED = N*NUM_PACKETS
// - TS_W         16   timestamp bits, stored in payload bits [TS_W-1:0]; TS_W <= data_width
// - CNT_W        32   width of all counters and accumulators
// - TIMEOUT_CYC  4096 idle cycles in RUN before timeout
// PORTS
// - clk             in   1              system clock
// - rstn            in   1              synchronous active-low reset
// - r_valid_pe      in   N              PE->NoC injection valid
// - r_ready_pe      in   N              NoC->PE injection ready; inject = valid & ready
// - w_valid_pe      in   N              NoC->PE ejection valid; no backpressure
// - w_data_pe       in   N*total_width  ejected flits; lane i at [i*total_width +: total_width]
// - cycle_now       out  TS_W           free-running cycle count; PEs stamp flits with it
// - inj_total       out  CNT_W          accepted injections, all lanes
// - ej_total        out  CNT_W          ejections, all lanes
// - run_cycles      out  CNT_W          cycles from first injection to completion
// - lat_sum         out  CNT_W          sum of ejected-packet latencies
// - lat_max         out  TS_W           worst single-packet latency
// - done            out  1              sticky: all EXPECTED packets injected and ejected
// - timeout         out  1              sticky: RUN stalled for TIMEOUT_CYC cycles
// BEHAVIOUR
// - Reset: rstn low at a clk edge clears all outputs, counters and the FSM to IDLE. This applies mid-run too; no partial state survives.
// - cycle_now: increments every cycle after reset and wraps modulo 2^TS_W.
// - FSM IDLE -> RUN: on the first cycle with any inject. run_cycles counts 1 in that same cycle.
// - FSM RUN -> DONE: when inj_total and ej_total both equal EXPECTED (values including this cycle's events) and no r_valid_pe/w_valid_pe bit is high. run_cycles does not count the DONE-entry cycle.
// - FSM RUN -> TIMEOUT: the idle counter resets on any inject or eject and otherwise increments. Reaching TIMEOUT_CYC sets timeout. DONE takes precedence if both fire in the same cycle.
// - DONE and TIMEOUT are terminal until reset. Counters freeze; stray valids are ignored.
// - Per cycle: inj_total += popcount(r_valid_pe & r_ready_pe) and ej_total += popcount(w_valid_pe). All lanes are handled in the same cycle, up to N per cycle.
// - Latency per ejected lane: (cycle_now - ts) mod 2^TS_W. A wrapped stamp therefore gives the correct difference if the true latency < 2^TS_W.
// - lat_sum: adds the sum of all lanes' latencies each cycle.
// - lat_max: updated to the max of its current value and every lane's latency.
// - Events in IDLE: ejections are counted. An ejection in IDLE without any prior inject is a stimulus error; it is counted anyway.
// - Saturation: every CNT_W counter saturates at all-ones and never wraps.
// - Latency: all outputs are registered, 1 cycle after the sampled edge. There is no combinational path from inputs to outputs.
// STRUCTURE
// - Shared package noc_perf_pkg holds the FSM state enum (IDLE, RUN, DONE, TIMEOUT) and the popcount and saturating-add functions.
// - One sub-module, noc_lat_reduce: combinational N-lane latency compute with sum tree and max tree, registered in the parent.
// - Remaining RTL is the FSM plus counters in the parent.
// TESTING
// - X=1,Y=2,NUM_PACKETS=10: random PEs, rate 1 -> done=1, inj_total=ej_total=20, timeout=0; run_cycles matches the bench count.
// - Both lanes inject in the same cycle (r_valid=r_ready=2'b11), then both eject together -> inj_total steps by 2 and ej_total steps by 2.
// - r_valid=1, r_ready=0 for 5 cycles -> inj_total stays 0 and the FSM stays IDLE.
// - TS_W=4: flit stamped 14 ejected at cycle_now=3 -> latency 5 and lat_max=5.
// - Inject 3 packets then stop; TIMEOUT_CYC=16 -> timeout=1 exactly 16 cycles after the last event; done stays 0.
// - rstn low for 1 cycle mid-RUN -> all outputs 0 next cycle, FSM in IDLE; the next inject restarts run_cycles at 1.

Source files
------------

// File: rtl/noc_perf_pkg.sv
// Shared types and helpers for the NoC performance monitor.
//   state_e   : monitor FSM states
//   popcount  : set-bit count of a lane mask (up to 64 lanes)
//   sat_add   : add that clamps at the all-ones value of a w-bit counter (w <= 64)
package noc_perf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } state_e;

  function automatic logic [6:0] popcount(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + 7'(v[i]);
    return c;
  endfunction

  // The 65-bit intermediate keeps the carry, so a 64-bit counter clamps too.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] s;
    logic [64:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    return (s > lim) ? lim[63:0] : s[63:0];
  endfunction

endpackage

// File: rtl/noc_perf_monitor_lat_reduce.sv
// noc_lat_reduce: combinational per-lane latency plus sum and max reduction.
//   cycle_now : current timestamp
//   w_valid   : per-lane ejection valid
//   w_data    : ejected flits, lane i at [i*TW +: TW]; stamp in bits [TS_W-1:0]
//   lat_sum   : sum of valid lanes' latencies (wide enough to never overflow)
//   lat_max   : largest valid lane latency, 0 when no lane is valid
module noc_lat_reduce #(
  parameter int N     = 2,
  parameter int TW    = 258,
  parameter int TS_W  = 16,
  parameter int SUM_W = 18
) (
  input  logic [TS_W-1:0]  cycle_now,
  input  logic [N-1:0]     w_valid,
  input  logic [N*TW-1:0]  w_data,
  output logic [SUM_W-1:0] lat_sum,
  output logic [TS_W-1:0]  lat_max
);

  logic [N-1:0][TS_W-1:0] lat;

  // Modulo-2^TS_W subtraction: a stamp taken before the counter wrapped still
  // yields the true latency as long as that latency is below 2^TS_W.
  for (genvar g = 0; g < N; g++) begin : g_lane
    assign lat[g] = w_valid[g] ? (cycle_now - w_data[g*TW +: TS_W]) : '0;
  end

  always_comb begin
    lat_sum = '0;
    lat_max = '0;
    for (int i = 0; i < N; i++) begin
      lat_sum = lat_sum + SUM_W'(lat[i]);
      if (lat[i] > lat_max) lat_max = lat[i];
    end
  end

  // Header and upper payload bits are not needed here.
  logic unused_flit;
  assign unused_flit = ^w_data;

endmodule

// File: rtl/noc_perf_monitor.sv
// noc_perf_monitor: taps PE-side NoC buses, counts injections/ejections, times
// the run and accumulates per-packet latency from a stamp carried in each flit.
//   clk, rstn  : clock, synchronous active-low reset
//   r_valid_pe / r_ready_pe : injection handshake per lane (inject = valid & ready)
//   w_valid_pe / w_data_pe  : ejection per lane, no backpressure
//   cycle_now  : free-running stamp source for the PEs
//   inj_total, ej_total, run_cycles, lat_sum, lat_max : saturating statistics
//   done, timeout : sticky terminal flags
// All outputs come straight from flops.
module noc_perf_monitor
  import noc_perf_pkg::*;
#(
  parameter int X           = 1,
  parameter int Y           = 2,
  parameter int x_size      = 1,
  parameter int y_size      = 1,
  parameter int data_width  = 256,
  parameter int NUM_PACKETS = 10,
  parameter int TS_W        = 16,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                                         clk,
  input  logic                                         rstn,
  input  logic [X*Y-1:0]                               r_valid_pe,
  input  logic [X*Y-1:0]                               r_ready_pe,
  input  logic [X*Y-1:0]                               w_valid_pe,
  input  logic [X*Y*(x_size+y_size+data_width)-1:0]    w_data_pe,
  output logic [TS_W-1:0]                              cycle_now,
  output logic [CNT_W-1:0]                             inj_total,
  output logic [CNT_W-1:0]                             ej_total,
  output logic [CNT_W-1:0]                             run_cycles,
  output logic [CNT_W-1:0]                             lat_sum,
  output logic [TS_W-1:0]                              lat_max,
  output logic                                         done,
  output logic                                         timeout
);

  localparam int N        = X * Y;
  localparam int TW       = x_size + y_size + data_width;
  localparam int EXPECTED = N * NUM_PACKETS;
  localparam int IDLE_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int SUM_W    = TS_W + $clog2(N + 1);

  state_e            state_q, state_d;
  logic [TS_W-1:0]   cycle_q, cycle_d;
  logic [CNT_W-1:0]  inj_q, inj_d, ej_q, ej_d, run_q, run_d, lsum_q, lsum_d;
  logic [TS_W-1:0]   lmax_q, lmax_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              done_q, done_d, to_q, to_d;

  logic [SUM_W-1:0]  lane_sum;
  logic [TS_W-1:0]   lane_max;

  noc_lat_reduce #(.N(N), .TW(TW), .TS_W(TS_W), .SUM_W(SUM_W)) u_lat (
    .cycle_now (cycle_q),
    .w_valid   (w_valid_pe),
    .w_data    (w_data_pe),
    .lat_sum   (lane_sum),
    .lat_max   (lane_max)
  );

  logic [N-1:0]     inject;
  logic [6:0]       inj_cnt, ej_cnt;
  logic             any_event, any_valid;
  logic [CNT_W-1:0] inj_nxt, ej_nxt, lsum_nxt, run_nxt;
  logic [TS_W-1:0]  lmax_nxt;

  always_comb begin
    inject    = r_valid_pe & r_ready_pe;
    inj_cnt   = popcount(64'(inject));
    ej_cnt    = popcount(64'(w_valid_pe));
    any_event = (|inject) | (|w_valid_pe);
    any_valid = (|r_valid_pe) | (|w_valid_pe);
    inj_nxt   = CNT_W'(sat_add(64'(inj_q), 64'(inj_cnt), CNT_W));
    ej_nxt    = CNT_W'(sat_add(64'(ej_q), 64'(ej_cnt), CNT_W));
    lsum_nxt  = CNT_W'(sat_add(64'(lsum_q), 64'(lane_sum), CNT_W));
    run_nxt   = CNT_W'(sat_add(64'(run_q), 64'd1, CNT_W));
    lmax_nxt  = (lane_max > lmax_q) ? lane_max : lmax_q;
  end

  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q + TS_W'(1);
    inj_d   = inj_q;
    ej_d    = ej_q;
    run_d   = run_q;
    lsum_d  = lsum_q;
    lmax_d  = lmax_q;
    idle_d  = idle_q;
    done_d  = done_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE: begin
        // Ejections before any inject are stimulus errors but still counted.
        inj_d  = inj_nxt;
        ej_d   = ej_nxt;
        lsum_d = lsum_nxt;
        lmax_d = lmax_nxt;
        idle_d = '0;
        if (|inject) begin
          state_d = RUN;
          run_d   = run_nxt;
        end
      end
      RUN: begin
        inj_d  = inj_nxt;
        ej_d   = ej_nxt;
        lsum_d = lsum_nxt;
        lmax_d = lmax_nxt;
        idle_d = any_event ? '0 : idle_q + IDLE_W'(1);
        // Completion is checked first so it wins over a same-cycle timeout;
        // the DONE-entry cycle is deliberately left out of run_cycles.
        if (inj_nxt == CNT_W'(EXPECTED) && ej_nxt == CNT_W'(EXPECTED) && !any_valid) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          run_d = run_nxt;
          if (idle_d == IDLE_W'(TIMEOUT_CYC)) begin
            state_d = TIMEOUT;
            to_d    = 1'b1;
          end
        end
      end
      default: ;  // DONE / TIMEOUT: everything frozen until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cycle_q <= '0;
      inj_q   <= '0;
      ej_q    <= '0;
      run_q   <= '0;
      lsum_q  <= '0;
      lmax_q  <= '0;
      idle_q  <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      inj_q   <= inj_d;
      ej_q    <= ej_d;
      run_q   <= run_d;
      lsum_q  <= lsum_d;
      lmax_q  <= lmax_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
      to_q    <= to_d;
    end
  end

  assign cycle_now  = cycle_q;
  assign inj_total  = inj_q;
  assign ej_total   = ej_q;
  assign run_cycles = run_q;
  assign lat_sum    = lsum_q;
  assign lat_max    = lmax_q;
  assign done       = done_q;
  assign timeout    = to_q;

endmodule

// File: tb/tb_noc_perf_monitor.sv
// Bench for noc_perf_monitor: X=1, Y=2, 10 packets per PE, 4-bit stamps,
// 8-bit counters (so saturation is reachable) and a 16-cycle timeout.
module tb_noc_perf_monitor;

  localparam int N      = 2;
  localparam int TS_W   = 4;
  localparam int TW     = 10;
  localparam int CNT_W  = 8;
  localparam int NP     = 10;
  localparam int EXP    = N * NP;
  localparam int TO     = 16;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int TSMASK = (1 << TS_W) - 1;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    r_valid, r_ready, w_valid;
  logic [N*TW-1:0] w_data;
  logic [TS_W-1:0] cycle_now, lat_max;
  logic [CNT_W-1:0] inj_total, ej_total, run_cycles, lat_sum;
  logic            done, timeout;

  always #5 clk = ~clk;

  noc_perf_monitor #(
    .X(1), .Y(2), .x_size(1), .y_size(1), .data_width(8), .NUM_PACKETS(NP),
    .TS_W(TS_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .r_valid_pe(r_valid), .r_ready_pe(r_ready),
    .w_valid_pe(w_valid), .w_data_pe(w_data), .cycle_now(cycle_now),
    .inj_total(inj_total), .ej_total(ej_total), .run_cycles(run_cycles),
    .lat_sum(lat_sum), .lat_max(lat_max), .done(done), .timeout(timeout)
  );

  typedef struct {
    int cyc, inj, ej, run, lsum, lmax, dn, to;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [1:0] rv, rr, wv;
    int e_inj, e_ej, e_run;
  } vec_t;
  vec_t tbl[9];

  int checks = 0;
  int errors = 0;

  // behavioural reference: 0=IDLE 1=RUN 2=DONE 3=TIMEOUT
  int m_cyc, m_state, m_inj, m_ej, m_run, m_lsum, m_lmax, m_idle, m_done, m_to;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    int ni, ne, ls, lm, l;
    bit any;
    if (!rstn) begin
      m_cyc = 0; m_state = 0; m_inj = 0; m_ej = 0; m_run = 0;
      m_lsum = 0; m_lmax = 0; m_idle = 0; m_done = 0; m_to = 0;
      return;
    end
    ni = 0; ne = 0; ls = 0; lm = 0;
    for (int i = 0; i < N; i++) begin
      if (r_valid[i] && r_ready[i]) ni++;
      if (w_valid[i]) begin
        ne++;
        l = (m_cyc - int'(w_data[i*TW +: TS_W])) & TSMASK;
        ls += l;
        if (l > lm) lm = l;
      end
    end
    any = (r_valid != 0) || (w_valid != 0);
    if (m_state <= 1) begin
      m_inj  = sat(m_inj + ni);
      m_ej   = sat(m_ej + ne);
      m_lsum = sat(m_lsum + ls);
      if (lm > m_lmax) m_lmax = lm;
      if (m_state == 0) begin
        m_idle = 0;
        if (ni > 0) begin m_state = 1; m_run = 1; end
      end else begin
        m_idle = (ni + ne > 0) ? 0 : m_idle + 1;
        if (m_inj == EXP && m_ej == EXP && !any) begin
          m_state = 2; m_done = 1;
        end else begin
          m_run = sat(m_run + 1);
          if (m_idle == TO) begin m_state = 3; m_to = 1; end
        end
      end
    end
    m_cyc = (m_cyc + 1) & TSMASK;
  endtask

  // One clock: predict, push, wait for the edge, pop and compare.
  task automatic cyc();
    exp_t e;
    model_step();
    exp_q.push_back('{m_cyc, m_inj, m_ej, m_run, m_lsum, m_lmax, m_done, m_to});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("cycle_now", 32'(cycle_now), e.cyc);
    chk("inj_total", 32'(inj_total), e.inj);
    chk("ej_total", 32'(ej_total), e.ej);
    chk("run_cycles", 32'(run_cycles), e.run);
    chk("lat_sum", 32'(lat_sum), e.lsum);
    chk("lat_max", 32'(lat_max), e.lmax);
    chk("done", 32'(done), e.dn);
    chk("timeout", 32'(timeout), e.to);
  endtask

  task automatic drive(input logic [1:0] rv, input logic [1:0] rr, input logic [1:0] wv,
                       input int ts0, input int ts1);
    r_valid = rv;
    r_ready = rr;
    w_valid = wv;
    w_data[0 +: TW]  = {6'($urandom), 4'(ts0)};
    w_data[TW +: TW] = {6'($urandom), 4'(ts1)};
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 0, 0);
    cyc();
    cyc();
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int pend[2][$];
    int left[2];
    int tb_run, guard, ts;
    bit active;

    tbl[0] = '{2'b11, 2'b00, 2'b00, 0, 0, 0};
    tbl[1] = '{2'b11, 2'b00, 2'b00, 0, 0, 0};
    tbl[2] = '{2'b11, 2'b00, 2'b00, 0, 0, 0};
    tbl[3] = '{2'b11, 2'b00, 2'b00, 0, 0, 0};
    tbl[4] = '{2'b11, 2'b00, 2'b00, 0, 0, 0};
    tbl[5] = '{2'b11, 2'b11, 2'b00, 2, 0, 1};
    tbl[6] = '{2'b00, 2'b00, 2'b11, 2, 2, 2};
    tbl[7] = '{2'b00, 2'b00, 2'b00, 2, 2, 3};
    tbl[8] = '{2'b01, 2'b01, 2'b00, 3, 2, 4};

    // reset state
    do_reset();
    chk("rst_cycle", 32'(cycle_now), 0);
    chk("rst_inj", 32'(inj_total), 0);
    chk("rst_ej", 32'(ej_total), 0);
    chk("rst_run", 32'(run_cycles), 0);
    chk("rst_lsum", 32'(lat_sum), 0);
    chk("rst_lmax", 32'(lat_max), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_to", 32'(timeout), 0);

    // table: valid without ready, then dual inject, then dual eject
    foreach (tbl[k]) begin
      drive(tbl[k].rv, tbl[k].rr, tbl[k].wv, m_cyc, m_cyc);
      cyc();
      chk("tbl_inj", 32'(inj_total), tbl[k].e_inj);
      chk("tbl_ej", 32'(ej_total), tbl[k].e_ej);
      chk("tbl_run", 32'(run_cycles), tbl[k].e_run);
    end

    // random PEs at rate 1, random ready, random ejection timing
    do_reset();
    left[0] = NP; left[1] = NP;
    tb_run = 0; guard = 0; active = 0;
    while ((left[0] + left[1] + pend[0].size() + pend[1].size()) > 0 && guard < 500) begin
      guard++;
      for (int i = 0; i < N; i++) begin
        r_valid[i] = (left[i] > 0);
        r_ready[i] = 1'($urandom_range(0, 1));
        w_valid[i] = 1'b0;
        w_data[i*TW +: TW] = {6'($urandom), 4'(0)};
        if (pend[i].size() > 0 && $urandom_range(0, 3) != 0) begin
          ts = pend[i].pop_front();
          w_valid[i] = 1'b1;
          w_data[i*TW +: TS_W] = 4'(ts);
        end
        if (r_valid[i] && r_ready[i]) begin
          pend[i].push_back(m_cyc);
          left[i]--;
          active = 1;
        end
      end
      if (active) tb_run++;
      cyc();
    end
    chk("rand_bound", 32'(guard < 500), 1);
    drive(2'b00, 2'b00, 2'b00, 0, 0);
    cyc();
    chk("rand_done", 32'(done), 1);
    chk("rand_inj", 32'(inj_total), EXP);
    chk("rand_ej", 32'(ej_total), EXP);
    chk("rand_to", 32'(timeout), 0);
    chk("rand_run", 32'(run_cycles), tb_run);
    drive(2'b11, 2'b11, 2'b11, 0, 0);
    cyc();
    cyc();
    chk("done_freeze_inj", 32'(inj_total), EXP);
    chk("done_freeze_ej", 32'(ej_total), EXP);

    // stamp 14 ejected at cycle_now 3 wraps to latency 5
    do_reset();
    guard = 0;
    while (m_cyc != 3 && guard < 40) begin guard++; cyc(); end
    drive(2'b00, 2'b00, 2'b01, 14, 0);
    cyc();
    chk("wrap_lmax", 32'(lat_max), 5);
    chk("wrap_lsum", 32'(lat_sum), 5);
    chk("wrap_ej", 32'(ej_total), 1);
    drive(2'b00, 2'b00, 2'b00, 0, 0);
    cyc();

    // three injects then silence: timeout exactly 16 cycles after last event
    do_reset();
    for (int k = 0; k < 3; k++) begin drive(2'b01, 2'b01, 2'b00, 0, 0); cyc(); end
    drive(2'b00, 2'b00, 2'b00, 0, 0);
    for (int k = 1; k <= TO; k++) begin
      cyc();
      if (k == TO - 1) chk("to_early", 32'(timeout), 0);
    end
    chk("to_set", 32'(timeout), 1);
    chk("to_done", 32'(done), 0);
    drive(2'b11, 2'b11, 2'b00, 0, 0);
    cyc();
    chk("to_freeze_inj", 32'(inj_total), 3);

    // reset in the middle of a run
    do_reset();
    drive(2'b11, 2'b11, 2'b00, 0, 0);
    cyc();
    drive(2'b00, 2'b00, 2'b00, 0, 0);
    cyc();
    chk("mid_run_before", 32'(run_cycles), 2);
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    chk("mid_inj", 32'(inj_total), 0);
    chk("mid_run", 32'(run_cycles), 0);
    chk("mid_cycle", 32'(cycle_now), 0);
    drive(2'b01, 2'b01, 2'b00, 0, 0);
    cyc();
    chk("mid_restart_run", 32'(run_cycles), 1);
    chk("mid_restart_inj", 32'(inj_total), 1);

    // saturation: 20 ejections of latency 15 in IDLE -> 300 clamps to 255
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(2'b00, 2'b00, 2'b11, (m_cyc + 1) & TSMASK, (m_cyc + 1) & TSMASK);
      cyc();
    end
    chk("sat_ej", 32'(ej_total), 20);
    chk("sat_lsum", 32'(lat_sum), CMAX);
    chk("sat_lmax", 32'(lat_max), 15);
    chk("sat_run", 32'(run_cycles), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
